alu_seq_muldiv: RTL and testbench
=================================

Name: alu_seq_muldiv

Overview:
Parametrised, registered successor to the combinational MIPS ALU, placed in the EX stage.
- Single-cycle ops (add/sub/logic/shift/compare/branch) complete in one cycle.
- Multiply runs iteratively over DATA_W cycles and writes architectural HI/LO registers, which MFHI/MFLO read back.
- Valid/ready handshakes on both sides let the pipeline stall on long ops.

Parameters:
DATA_W, 32, operand/result width (power of two, >=8)
SHAMT_W, 5, shift-amount width; must equal log2(DATA_W)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operation offered
in_ready  out  1  unit accepts operation this cycle
op_sel  in  6  funct code
shamt  in  SHAMT_W  shift amount
input1  in  DATA_W  operand A (rs)
input2  in  DATA_W  operand B (rt)
out_valid  out  1  result/branch_taken valid
out_ready  in  1  consumer accepts result
result  out  DATA_W  registered result
branch_taken  out  1  registered branch decision
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register
busy  out  1  iterative op in progress

Behaviour:
Reset:
- Asynchronous, active-high rst; clk is the only clock.
- On reset: state=IDLE; out_valid, result, branch_taken, hi, lo, busy all = 0.

Handshake:
- Accept when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Output holds stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new result is loaded in the same cycle.

Funct codes and results:
- ADDU 100001, SUBU 100011: wrap-around, mod 2^DATA_W.
- AND 100100, OR 100101, XOR 100110.
- SLL 000000: input2<<shamt. SRL 000010: logical. SRA 000011: arithmetic.
- SLT 101010 (signed), SLTU 101011 (unsigned): result = {0..,1}/0.
- BEQ 001001, BNE 001010, BGEZ 001011, BLTZ 001100, BLEZ 000111, BGTZ 001000:
  - Set branch_taken on the signed/equality test of input1 (and input2 for BEQ/BNE).
  - result = 0, except BGTZ, where result = input1.
- MFHI 010000: result = hi. MFLO 010010: result = lo.
- HALT 111111 and undefined codes: result = 0, branch_taken = 0, still produce out_valid.
- branch_taken = 0 for every non-branch op.

Latency:
- Single-cycle ops accepted at edge T: out_valid high after edge T+1.

Multiply, MULTU 011001 / MULT 011000 (FSM IDLE -> MUL -> DONE -> IDLE):
- Accept: latch operands. For MULT, latch magnitudes plus sign = sA^sB. busy=1, count=0.
- MUL: one shift-add step per cycle over a 2*DATA_W accumulator. Exit after DATA_W steps.
- DONE: negate the accumulator if MULT and sign=1; {hi,lo} <= product; out_valid=1 with result = lo and branch_taken = 0; busy=0.
- out_valid is high DATA_W+1 cycles after acceptance.
- hi/lo change only in DONE. Single-cycle ops never alter hi/lo.
- MFHI accepted immediately after a multiply returns the new HI (in_ready is low until DONE retires).

Boundaries:
- Signed MULT of most-negative values uses the DATA_W-bit magnitude with the top bit valid; -2^(N-1) * -2^(N-1) = 2^(2N-2).
- rst mid-multiply aborts: state=IDLE, hi=lo=0, no out_valid.
- Operands that change after acceptance do not affect the op in flight.

Optional Feature:
ALU_DIV_EN
- Defined: adds DIVU 011011 and DIV 011010 as iterative restoring divide through the same MUL-style FSM (state DIV, DATA_W steps, DONE).
  - lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero: lo = all ones, hi = dividend, same latency.
- Undefined: 011011/011010 behave as undefined codes (single cycle, result 0, hi/lo unchanged).

Test Plan:
- Reset mid-op: rst while busy -> hi=0, lo=0, out_valid=0, in_ready=1 the next cycle.
- Back-to-back ops with out_ready=1: ADDU 0xFFFFFFFF+1 then SRA 0x80000000 shamt 4 -> results 0x00000000, then 0xF8000000 on consecutive cycles.
- Backpressure: out_ready=0 for 3 cycles after SLT(-1,1) -> result=1 held, in_ready=0, next op accepted only after out_ready=1.
- MULTU 0xFFFFFFFF*2 -> out_valid 33 cycles after accept; hi=0x00000001, lo=0xFFFFFFFE. Then MFHI -> result 0x00000001.
- MULT 0xFFFFFFFF*2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- Branches: BGTZ input1=5 -> branch_taken=1, result=5. BLEZ input1=0 -> 1. BNE 7,7 -> 0. With ALU_DIV_EN, DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU x/0 -> lo=0xFFFFFFFF.

Source files
------------

// File: rtl/alu_seq_muldiv.sv
// Registered EX-stage ALU: single-cycle ops plus an iterative shift-add multiply writing HI/LO.
// Defining ALU_DIV_EN adds DIV/DIVU as an iterative restoring divide through the same FSM.
module alu_seq_muldiv #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         op_sel,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  input1,
  input  logic [DATA_W-1:0]  input2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               branch_taken,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo,
  output logic               busy
);

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_BLEZ  = 6'b000111;
  localparam logic [5:0] F_BGTZ  = 6'b001000;
  localparam logic [5:0] F_BEQ   = 6'b001001;
  localparam logic [5:0] F_BNE   = 6'b001010;
  localparam logic [5:0] F_BGEZ  = 6'b001011;
  localparam logic [5:0] F_BLTZ  = 6'b001100;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     opnd_q, opnd_d;
  logic                  neg_q, neg_d, rneg_q, rneg_d, is_div_q, is_div_d, dz_q, dz_d;
  logic [DATA_W-1:0]     result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic                  bt_q, bt_d, ov_q, ov_d;

  logic [DATA_W-1:0]     alu_res;
  logic                  alu_bt;
  logic                  accept, op_signed, a_neg, b_neg;
  logic [DATA_W-1:0]     a_mag, b_mag;
  logic [DATA_W:0]       mul_sum;
  logic [2*DATA_W-1:0]   mul_step, div_step, prod;
  logic [2*DATA_W:0]     div_shl;
  logic [DATA_W:0]       div_diff;
  logic [DATA_W-1:0]     quo, rem, fin_hi, fin_lo;

  assign in_ready     = (state_q == S_IDLE) && (!ov_q || out_ready);
  assign accept       = in_valid && in_ready;
  assign busy         = (state_q == S_MUL) || (state_q == S_DIV);
  assign out_valid    = ov_q;
  assign result       = result_q;
  assign branch_taken = bt_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

  always_comb begin
    alu_res = '0;
    alu_bt  = 1'b0;
    case (op_sel)
      F_ADDU: alu_res = input1 + input2;
      F_SUBU: alu_res = input1 - input2;
      F_AND:  alu_res = input1 & input2;
      F_OR:   alu_res = input1 | input2;
      F_XOR:  alu_res = input1 ^ input2;
      F_SLL:  alu_res = input2 << shamt;
      F_SRL:  alu_res = input2 >> shamt;
      F_SRA:  alu_res = $unsigned($signed(input2) >>> shamt);
      F_SLT:  alu_res = DATA_W'($signed(input1) < $signed(input2));
      F_SLTU: alu_res = DATA_W'(input1 < input2);
      F_BEQ:  alu_bt  = (input1 == input2);
      F_BNE:  alu_bt  = (input1 != input2);
      F_BGEZ: alu_bt  = !input1[DATA_W-1];
      F_BLTZ: alu_bt  = input1[DATA_W-1];
      F_BLEZ: alu_bt  = input1[DATA_W-1] || (input1 == '0);
      F_BGTZ: begin
        alu_bt  = !input1[DATA_W-1] && (input1 != '0);
        alu_res = input1;
      end
      F_MFHI: alu_res = hi_q;
      F_MFLO: alu_res = lo_q;
      default: ;
    endcase
  end

  // Iterative ops run on magnitudes; signs are re-applied when the op retires.
  assign op_signed = (op_sel == F_MULT) || (op_sel == F_DIV);
  assign a_neg     = op_signed && input1[DATA_W-1];
  assign b_neg     = op_signed && input2[DATA_W-1];
  assign a_mag     = a_neg ? -input1 : input1;
  assign b_mag     = b_neg ? -input2 : input2;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_step = {mul_sum, acc_q[DATA_W-1:1]};

  // Divide: acc = {remainder, dividend bits shifting into quotient}.
  assign div_shl  = {acc_q, 1'b0};
  assign div_diff = div_shl[2*DATA_W:DATA_W] - {1'b0, opnd_q};
  assign div_step = div_diff[DATA_W] ? div_shl[2*DATA_W-1:0]
                                     : {div_diff[DATA_W-1:0], div_shl[DATA_W-1:1], 1'b1};

  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = acc_q[DATA_W-1:0];
  assign rem  = acc_q[2*DATA_W-1:DATA_W];

  always_comb begin
    if (is_div_q) begin
      fin_lo = dz_q ? '1 : (neg_q ? -quo : quo);
      fin_hi = rneg_q ? -rem : rem;
    end else begin
      fin_lo = prod[DATA_W-1:0];
      fin_hi = prod[2*DATA_W-1:DATA_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    result_d = result_q;
    bt_d     = bt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ov_d     = ov_q;
    if (ov_q && out_ready) ov_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_sel)
            F_MULTU, F_MULT: begin
              acc_d    = {{DATA_W{1'b0}}, b_mag};
              opnd_d   = a_mag;
              neg_d    = a_neg ^ b_neg;
              rneg_d   = 1'b0;
              is_div_d = 1'b0;
              dz_d     = 1'b0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end
`ifdef ALU_DIV_EN
            F_DIVU, F_DIV: begin
              acc_d    = {{DATA_W{1'b0}}, a_mag};
              opnd_d   = b_mag;
              neg_d    = a_neg ^ b_neg;
              rneg_d   = a_neg;
              is_div_d = 1'b1;
              dz_d     = (input2 == '0);
              cnt_d    = '0;
              state_d  = S_DIV;
            end
`endif
            default: begin
              result_d = alu_res;
              bt_d     = alu_bt;
              ov_d     = 1'b1;
            end
          endcase
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_DIV) ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHAMT_W'(DATA_W-1)) state_d = S_DONE;
      end
      S_DONE: begin
        hi_d     = fin_hi;
        lo_d     = fin_lo;
        result_d = fin_lo;
        bt_d     = 1'b0;
        ov_d     = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      bt_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      bt_q     <= bt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ov_q     <= ov_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv: directed cases then randomized ops with random backpressure.
module tb_alu_seq_muldiv;
  localparam int W = 32;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, branch_taken, busy;
  logic [5:0]    op_sel;
  logic [4:0]    shamt;
  logic [W-1:0]  input1, input2, result, hi, lo;

  alu_seq_muldiv #(.DATA_W(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
    .shamt(shamt), .input1(input1), .input2(input2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .branch_taken(branch_taken),
    .hi(hi), .lo(lo), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         bt;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           iter;
    int           acc_cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         em;
  int           n_cmp = 0, n_err = 0, cyc = 0, hold_until = 0;
  bit           rnd_mode = 0, prev_hold = 0;
  logic [W-1:0] held_res, mhi = '0, mlo = '0;
  logic         held_bt;

  logic [5:0] op_tbl [0:23] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
                                6'b000000, 6'b000010, 6'b000011, 6'b101010, 6'b101011,
                                6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b000111,
                                6'b001000, 6'b010000, 6'b010010, 6'b011000, 6'b011001,
                                6'b011010, 6'b011011, 6'b111111, 6'b010101};

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (cyc < hold_until) out_ready = 0;
      else if (rnd_mode)    out_ready = ($urandom_range(0, 3) != 0);
      else                  out_ready = 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: architectural effect of one op, straight from the ISA arithmetic.
  task automatic model(input logic [5:0] op, input logic [4:0] sh,
                       input logic [W-1:0] a, input logic [W-1:0] b, output exp_t e);
    longint       sa, sbv;
    logic [63:0]  p, q, r;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    e.res = '0; e.bt = 0; e.iter = 0; e.acc_cyc = 0;
    case (op)
      6'b100001: e.res = a + b;
      6'b100011: e.res = a - b;
      6'b100100: e.res = a & b;
      6'b100101: e.res = a | b;
      6'b100110: e.res = a ^ b;
      6'b000000: e.res = b << sh;
      6'b000010: e.res = b >> sh;
      6'b000011: e.res = $unsigned($signed(b) >>> sh);
      6'b101010: e.res = (sa < sbv) ? 1 : 0;
      6'b101011: e.res = (a < b) ? 1 : 0;
      6'b001001: e.bt = (a == b);
      6'b001010: e.bt = (a != b);
      6'b001011: e.bt = (sa >= 0);
      6'b001100: e.bt = (sa < 0);
      6'b000111: e.bt = (sa <= 0);
      6'b001000: begin e.bt = (sa > 0); e.res = a; end
      6'b010000: e.res = mhi;
      6'b010010: e.res = mlo;
      6'b011001: begin
        p = {32'b0, a} * {32'b0, b};
        mhi = p[63:32]; mlo = p[31:0]; e.res = mlo; e.iter = 1;
      end
      6'b011000: begin
        p = sa * sbv;
        mhi = p[63:32]; mlo = p[31:0]; e.res = mlo; e.iter = 1;
      end
`ifdef ALU_DIV_EN
      6'b011011, 6'b011010: begin
        if (b == 0) begin
          mlo = '1; mhi = a;
        end else if (op == 6'b011011) begin
          mlo = a / b; mhi = a % b;
        end else begin
          q = sa / sbv; r = sa % sbv;
          mlo = q[31:0]; mhi = r[31:0];
        end
        e.res = mlo; e.iter = 1;
      end
`endif
      default: ;
    endcase
    e.hi = mhi;
    e.lo = mlo;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] sh,
                       input logic [W-1:0] a, input logic [W-1:0] b, output int acc_c);
    exp_t e;
    int   guard = 0;
    in_valid = 1; op_sel = op; shamt = sh; input1 = a; input2 = b;
    acc_c = -1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    model(op, sh, a, b, e);
    e.acc_cyc = cyc + 1;
    acc_c = e.acc_cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    // Scramble the inputs so an op in flight that re-reads them is caught.
    in_valid = 0; op_sel = 6'($urandom); shamt = 5'($urandom);
    input1 = $urandom; input2 = $urandom;
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: rnd_opnd = 32'h0;
      1: rnd_opnd = 32'h1;
      2: rnd_opnd = 32'hFFFF_FFFF;
      3: rnd_opnd = 32'h8000_0000;
      4: rnd_opnd = 32'h7FFF_FFFF;
      5: rnd_opnd = 32'($urandom_range(0, 20)) - 32'd10;
      default: rnd_opnd = $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 0;
    end else begin
      if (out_valid && !out_ready) chk("in_ready_low_while_stalled", in_ready, 0);
      if (prev_hold) begin
        chk("held_valid", out_valid, 1);
        chk("held_result", result, held_res);
        chk("held_branch", branch_taken, held_bt);
      end
      if (out_valid && !prev_hold) begin
        if (sb.size() == 0) chk("unexpected_out_valid", out_valid, 0);
        else if (sb[0].iter) chk("iter_latency", 64'(cyc - sb[0].acc_cyc), W + 1);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        em = sb.pop_front();
        chk("result", result, em.res);
        chk("branch_taken", branch_taken, em.bt);
        chk("hi", hi, em.hi);
        chk("lo", lo, em.lo);
      end
      prev_hold = out_valid && !out_ready;
      held_res  = result;
      held_bt   = branch_taken;
    end
  end

  initial begin
    int c1, c2;
    rst = 1; in_valid = 0; op_sel = 0; shamt = 0; input1 = 0; input2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_branch", branch_taken, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    @(posedge clk); #1;

    issue(6'b100001, 0, 32'hFFFF_FFFF, 32'h1, c1);
    issue(6'b000011, 4, 32'h0, 32'h8000_0000, c2);
    chk("back_to_back_accept_gap", 64'(c2 - c1), 1);

    hold_until = cyc + 4;
    issue(6'b101010, 0, 32'hFFFF_FFFF, 32'h1, c1);
    issue(6'b011001, 0, 32'hFFFF_FFFF, 32'h2, c1);
    issue(6'b010000, 0, 32'h0, 32'h0, c1);
    issue(6'b011000, 0, 32'hFFFF_FFFF, 32'h2, c1);
    issue(6'b011000, 0, 32'h8000_0000, 32'h8000_0000, c1);
    issue(6'b010000, 0, 32'h0, 32'h0, c1);
    issue(6'b010010, 0, 32'h0, 32'h0, c1);
    issue(6'b001000, 0, 32'd5, 32'h0, c1);
    issue(6'b000111, 0, 32'd0, 32'h0, c1);
    issue(6'b001010, 0, 32'd7, 32'd7, c1);
    issue(6'b001001, 0, 32'd7, 32'd7, c1);
    issue(6'b011010, 0, 32'hFFFF_FFF9, 32'd2, c1);
    issue(6'b011011, 0, 32'h1234_5678, 32'd0, c1);
    issue(6'b011010, 0, 32'hFFFF_FFF9, 32'd0, c1);
    issue(6'b111111, 0, 32'd3, 32'd4, c1);

    // Reset in the middle of a multiply aborts it.
    issue(6'b011001, 0, 32'hDEAD_BEEF, 32'h1234_5678, c1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("busy_mid_mul", busy, 1);
    #1 rst = 1;
    sb.delete();
    mhi = '0; mlo = '0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;

    rnd_mode = 1;
    for (int i = 0; i < 250; i++) begin
      issue(op_tbl[$urandom_range(0, 23)], 5'($urandom), rnd_opnd(), rnd_opnd(), c1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rnd_mode = 0;

    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_queue_empty", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
